// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_down_count_reg.sv
// Down-counter register with clear, parallel load and non-wrapping decrement.
module down_count_reg
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    assign is_zero = (count == '0);
    assign is_one  = (count == WIDTH'(1));

    // Priority: clear, then load, then decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !is_zero) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a value on start, decrements on tick, pulses done at zero.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_next;
    logic   cnt_clr;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_is_zero;
    logic   cnt_is_one;

    down_count_reg #(
        .WIDTH(WIDTH)
    ) u_down_count_reg (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(load_val),
        .count   (count),
        .is_zero (cnt_is_zero),
        .is_one  (cnt_is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                // A zero load skips RUN entirely; count is already zero here.
                if (start && !abort) begin
                    if (load_val == '0) begin
                        state_next = DONE;
                    end else begin
                        cnt_load   = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (tick && !cnt_is_zero) begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

    localparam int unsigned W = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] load_val;
    logic         tick;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    countdown_timer #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .load_val(load_val),
        .tick    (tick),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; load_val = '0; tick = 1'b0; abort = 1'b0;
        #3;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        step(); step();
        rst = 1'b1;
        step();
        checks++; if (count !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle count %0d busy %b exp 0 0", count, busy); end
    endtask

    task automatic test_full_tick();
        int busy_cycles;
        start = 1'b1; load_val = 5'd5; tick = 1'b1;
        step();
        start = 1'b0;
        busy_cycles = busy ? 1 : 0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL full_load got %0d exp 5", count); end
        for (int i = 4; i >= 0; i--) begin
            step();
            if (busy) busy_cycles++;
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL full_count got %0d exp %0d", count, i); end
            checks++; if (done !== (i == 0)) begin errors++; $display("FAIL full_done got %b exp %b at count %0d", done, (i == 0), i); end
        end
        checks++; if (busy_cycles != 5) begin errors++; $display("FAIL full_busy_cycles got %0d exp 5", busy_cycles); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL full_after done %b busy %b count %0d exp 0 0 0", done, busy, count); end
        tick = 1'b0;
    endtask

    task automatic test_every_other();
        logic [W-1:0] exp_cnt [6] = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd0, 5'd0};
        logic         exp_dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        start = 1'b1; load_val = 5'd3; tick = 1'b0;
        step();
        start = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL eo_load got %0d exp 3", count); end
        for (int i = 0; i < 6; i++) begin
            tick = (i % 2 == 0);
            step();
            checks++; if (count !== exp_cnt[i]) begin errors++; $display("FAIL eo_count[%0d] got %0d exp %0d", i, count, exp_cnt[i]); end
            checks++; if (done !== exp_dn[i]) begin errors++; $display("FAIL eo_done[%0d] got %b exp %b", i, done, exp_dn[i]); end
        end
        tick = 1'b1;
        step(); step(); step();
        checks++; if (count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL eo_no_underflow count %0d done %b exp 0 0", count, done); end
        tick = 1'b0;
    endtask

    task automatic test_zero_load();
        start = 1'b1; load_val = 5'd0;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL zero_done done %b busy %b count %0d exp 1 0 0", done, busy, count); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after done %b busy %b exp 0 0", done, busy); end
    endtask

    task automatic test_abort();
        start = 1'b1; load_val = 5'd31; tick = 1'b0;
        step();
        start = 1'b0;
        checks++; if (count !== 5'd31) begin errors++; $display("FAIL abort_load got %0d exp 31", count); end
        tick = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++; if (count !== 5'd21) begin errors++; $display("FAIL abort_pre got %0d exp 21", count); end
        abort = 1'b1;
        step();
        checks++; if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_clear count %0d busy %b done %b exp 0 0 0", count, busy, done); end
        abort = 1'b0; tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", done); end
        end
        start = 1'b1; abort = 1'b1; load_val = 5'd6;
        step();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL abort_blocks_start busy %b count %0d done %b exp 0 0 0", busy, count, done); end
    endtask

    task automatic test_ignore_start();
        start = 1'b1; load_val = 5'd4; tick = 1'b0;
        step();
        start = 1'b0; tick = 1'b1;
        step();
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL ign_first got %0d exp 3", count); end
        start = 1'b1; load_val = 5'd9;
        step();
        start = 1'b0;
        checks++; if (count !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL ign_run_start count %0d busy %b exp 2 1", count, busy); end
        step();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL ign_third got %0d exp 1", count); end
        step();
        checks++; if (count !== 5'd0 || done !== 1'b1) begin errors++; $display("FAIL ign_done count %0d done %b exp 0 1", count, done); end
        tick = 1'b0; start = 1'b1; load_val = 5'd9;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL ign_done_start busy %b count %0d done %b exp 0 0 0", busy, count, done); end
    endtask

    task automatic test_async_reset();
        start = 1'b1; load_val = 5'd10; tick = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL arst_pre got %0d exp 7", count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_now count %0d busy %b done %b exp 0 0 0", count, busy, done); end
        step(); step();
        checks++; if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_held count %0d busy %b done %b exp 0 0 0", count, busy, done); end
        rst = 1'b1; start = 1'b1; load_val = 5'd2;
        step();
        start = 1'b0;
        checks++; if (count !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL arst_restart count %0d busy %b exp 2 1", count, busy); end
        step();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL arst_dec got %0d exp 1", count); end
        step();
        checks++; if (count !== 5'd0 || done !== 1'b1) begin errors++; $display("FAIL arst_done count %0d done %b exp 0 1", count, done); end
        tick = 1'b0;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_after done %b busy %b exp 0 0", done, busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_tick();
        test_every_other();
        test_zero_load();
        test_abort();
        test_ignore_start();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, 5, counter width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset is asynchronous and active-low; port keeps the codebase name rst.
REQ-004 Port: start  input  1  request to load load_val and begin counting; sampled only in IDLE.
REQ-005 Port: load_val  input  WIDTH  initial count value, captured when start is accepted.
REQ-006 Port: tick  input  1  count-enable strobe; each high cycle in RUN decrements count by 1.
REQ-007 Port: abort  input  1  cancels an operation in progress without a done pulse.
REQ-008 Port: count  output  WIDTH  current remaining count, registered.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle completion pulse, registered.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-012 In IDLE, start=1 with load_val!=0 and abort=0 SHALL set count<=load_val and move to RUN at the next edge.
REQ-013 In IDLE, start=1 with load_val==0 and abort=0 SHALL move directly to DONE; count stays 0.
REQ-014 In RUN, tick=1 SHALL decrement count by exactly 1 per cycle; tick=0 SHALL hold count.
REQ-015 In RUN, tick=1 with count==1 SHALL set count to 0 and move to DONE at the same edge.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
REQ-017 Latency: done SHALL be high in the cycle immediately after the edge that sampled the final tick.
REQ-018 count SHALL never wrap below 0; no decrement is applied outside RUN.
REQ-019 start SHALL be ignored in RUN and DONE; no re-load, no queuing.
REQ-020 abort=1 in RUN SHALL clear count to 0 and move to IDLE with no done pulse.
REQ-021 abort SHALL take priority over tick and start in the same cycle; abort in IDLE or DONE SHALL have no effect beyond blocking a simultaneous start.
REQ-022 busy SHALL equal (state==RUN), derived from registered state.
REQ-023 load_val SHALL be treated as unsigned; full range 0 to 2^WIDTH-1 is legal.

Reset
REQ-024 While rst=0, the FSM SHALL be in IDLE, with count=0, busy=0 and done=0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL discard the operation with no done pulse; after rst is released, the first start SHALL be accepted on the first active clk edge.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-027 One sub-module, down_count_reg, SHALL hold the WIDTH-bit register with parallel load, decrement and clear, plus a zero/one flag output; the FSM SHALL remain in countdown_timer.

Verification
REQ-028 Reset then start with load_val=5 and tick held high -> count reads 5,4,3,2,1,0; done is high exactly 1 cycle after the edge taking count to 0; busy is high for 5 cycles.
REQ-029 Start with load_val=3 and tick high every other cycle -> count holds between ticks; done is asserted once; no underflow.
REQ-030 Start with load_val=0 -> no RUN, done is high on the 2nd cycle after start, busy stays 0.
REQ-031 Start with load_val=31, 10 ticks, then abort with tick=1 in the same cycle -> count=0, IDLE, done never asserts.
REQ-032 Start with load_val=4, pulse start again with load_val=9 during RUN -> ignored; done after 4 ticks.
REQ-033 rst=0 asserted asynchronously mid-RUN at count=7 -> count=0, busy=0, done=0 immediately; a new start with load_val=2 completes normally after rst is released.
